// File: rtl/go_sequencer.sv
// go_sequencer: drives three delay stages in order (go pulse, wait for done),
// with abort/kill handling and a kill-latch clear phase.
// Optional per-stage watchdog is compiled in when GO_SEQ_TIMEOUT_EN is defined;
// without it WAIT only exits on done, abort or kill and o_timeout stays 0.
// All outputs are decoded from registered state and flags only.
module go_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 16
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_done1,
    input  logic       i_done2,
    input  logic       i_done3,
    input  logic       i_kill_ltchd,
    output logic       o_go1,
    output logic       o_go2,
    output logic       o_go3,
    output logic       o_kill1,
    output logic       o_kill2,
    output logic       o_kill3,
    output logic       o_kill_clr,
    output logic       o_busy,
    output logic       o_seq_done,
    output logic       o_error,
    output logic       o_timeout,
    output logic [1:0] o_stage
);

    // Elaboration-time sanity check on the watchdog configuration.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
        64'(TIMEOUT_CYCLES) >= (64'd1 << TMR_W)) begin : g_cfg_chk
        $error("go_sequencer: TIMEOUT_CYCLES out of range for TMR_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GO,
        S_WAIT,
        S_ABORT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic       preclr_q, preclr_d;     // CLEAR was entered from IDLE
    logic       err_q, err_d;
    logic       seq_done_q, seq_done_d;
    logic       done_sel;               // done of the active stage only
`ifdef GO_SEQ_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tmo_q, tmo_d;
`endif

    // Select the done input belonging to the active stage; others are ignored.
    always_comb begin
        done_sel = 1'b0;
        case (stage_q)
            2'd0:    done_sel = i_done1;
            2'd1:    done_sel = i_done2;
            2'd2:    done_sel = i_done3;
            default: done_sel = 1'b0;
        endcase
    end

    // State and flag registers; reset clears everything asynchronously.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            stage_q    <= 2'd0;
            preclr_q   <= 1'b0;
            err_q      <= 1'b0;
            seq_done_q <= 1'b0;
`ifdef GO_SEQ_TIMEOUT_EN
            tmr_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            preclr_q   <= preclr_d;
            err_q      <= err_d;
            seq_done_q <= seq_done_d;
`ifdef GO_SEQ_TIMEOUT_EN
            tmr_q      <= tmr_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    // Next-state logic for sequencing, abort priority and sticky status.
    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        preclr_d   = preclr_q;
        err_d      = err_q;
        seq_done_d = 1'b0;
`ifdef GO_SEQ_TIMEOUT_EN
        tmr_d      = tmr_q;
        tmo_d      = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    err_d    = 1'b0;
`ifdef GO_SEQ_TIMEOUT_EN
                    tmo_d    = 1'b0;
`endif
                    stage_d  = 2'd0;
                    preclr_d = i_kill_ltchd;
                    state_d  = i_kill_ltchd ? S_CLEAR : S_GO;
                end
            end
            S_CLEAR: begin
                if (preclr_q) begin
                    state_d = S_GO;
                end else begin
                    state_d = S_IDLE;
                    stage_d = 2'd0;
                end
            end
            S_GO: begin
`ifdef GO_SEQ_TIMEOUT_EN
                tmr_d = TMR_W'(TIMEOUT_CYCLES);
`endif
                if (i_abort) begin
                    state_d = S_ABORT;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
`ifdef GO_SEQ_TIMEOUT_EN
                tmr_d = tmr_q - TMR_W'(1);
`endif
                if (i_abort || i_kill_ltchd) begin
                    state_d = S_ABORT;
                    err_d   = 1'b1;
                end else if (done_sel) begin
                    if (stage_q == 2'd2) begin
                        state_d    = S_IDLE;
                        stage_d    = 2'd0;
                        seq_done_d = 1'b1;
                    end else begin
                        state_d = S_GO;
                        stage_d = stage_q + 2'd1;
                    end
                end
`ifdef GO_SEQ_TIMEOUT_EN
                // Expiry: the count reaches zero in this WAIT cycle.
                else if (tmr_q == TMR_W'(1)) begin
                    state_d = S_ABORT;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end
`endif
            end
            S_ABORT: begin
                state_d  = S_CLEAR;
                preclr_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                stage_d = 2'd0;
            end
        endcase
    end

    assign o_go1      = (state_q == S_GO)    && (stage_q == 2'd0);
    assign o_go2      = (state_q == S_GO)    && (stage_q == 2'd1);
    assign o_go3      = (state_q == S_GO)    && (stage_q == 2'd2);
    assign o_kill1    = (state_q == S_ABORT) && (stage_q == 2'd0);
    assign o_kill2    = (state_q == S_ABORT) && (stage_q == 2'd1);
    assign o_kill3    = (state_q == S_ABORT) && (stage_q == 2'd2);
    assign o_kill_clr = (state_q == S_CLEAR);
    assign o_busy     = (state_q != S_IDLE);
    assign o_seq_done = seq_done_q;
    assign o_error    = err_q;
    assign o_stage    = stage_q;
`ifdef GO_SEQ_TIMEOUT_EN
    assign o_timeout  = tmo_q;
`else
    assign o_timeout  = 1'b0;
`endif

endmodule
